effect_param_controller: RTL and testbench

Front-panel parameter controller for the audio effects chain. It debounces two push-buttons (up/down) and decodes the effect-select switches into a mode index. Each effect mode keeps its own saturating signed parameter register, with auto-repeat on held keys and a two-key reset to default. Outputs feed the effect datapath (gain, depth, etc.) and replace the single-effect, gain-only controller with a generic N-mode block.

---
 rtl/effect_param_controller.sv | 262 ++++++++++++++++++++++++++
 tb/tb_effect_param_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/effect_param_controller.sv
// Front-panel parameter controller: synchronises and debounces the up/down
// keys, decodes the mode switches and keeps one saturating signed parameter
// per effect mode, with auto-repeat on held keys and a two-key reset.
module effect_param_controller #(
    parameter int NUM_MODES       = 4,
    parameter int SW_W            = 2,
    parameter int PARAM_W         = 16,
    parameter int PARAM_MIN       = 1,
    parameter int PARAM_MAX       = 50,
    parameter int PARAM_DEFAULT   = 1,
    parameter int STEP            = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         key_up,
    input  logic                         key_down,
    input  logic [SW_W-1:0]              SW,
    output logic [$clog2(NUM_MODES)-1:0] mode,
    output logic signed [PARAM_W-1:0]    param,
    output logic                         param_changed
);

    localparam int MODE_W  = $clog2(NUM_MODES);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    typedef logic signed [PARAM_W-1:0] param_t;
    typedef logic signed [PARAM_W:0]   wide_t;

    localparam wide_t  MIN_X  = wide_t'(PARAM_MIN);
    localparam wide_t  MAX_X  = wide_t'(PARAM_MAX);
    localparam wide_t  STEP_X = wide_t'(STEP);
    localparam param_t DEF_P  = param_t'(PARAM_DEFAULT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_UP,
        S_HOLD_DN,
        S_REPEAT_UP,
        S_REPEAT_DN,
        S_BOTH,
        S_WAIT_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning: index 0 = up, index 1 = down (both active-low)
    // ------------------------------------------------------------------
    logic [1:0] key_raw;
    logic [1:0] key_db;

    assign key_raw = {key_down, key_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic            s1_q, s2_q, db_q, db_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            // Debounce: accept the synchronised level once it has disagreed
            // with the accepted level for DEBOUNCE_CYCLES consecutive cycles.
            always_comb begin
                db_d  = db_q;
                cnt_d = '0;
                if (s2_q != db_q) begin
                    if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
                        db_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end

            // Synchroniser and debounce state, released (high) out of reset.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    s1_q  <= 1'b1;
                    s2_q  <= 1'b1;
                    db_q  <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    s1_q  <= key_raw[gi];
                    s2_q  <= s1_q;
                    db_q  <= db_d;
                    cnt_q <= cnt_d;
                end
            end

            assign key_db[gi] = db_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Mode select
    // ------------------------------------------------------------------
    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic [MODE_W-1:0] mode_q, mode_d;

    // Out-of-range switch codes fall back to bypass.
    always_comb begin
        mode_d = '0;
        if (int'(sw_s2_q) < NUM_MODES) begin
            mode_d = MODE_W'(sw_s2_q);
        end
    end

    // Switch synchroniser and registered mode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            mode_q  <= '0;
        end else begin
            sw_s1_q <= SW;
            sw_s2_q <= sw_s1_q;
            mode_q  <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Parameter store and key FSM
    // ------------------------------------------------------------------
    // Entry 0 belongs to bypass; it is never written so it always reads default.
    param_t          params_q [NUM_MODES];
    param_t          params_d [NUM_MODES];
    state_t          state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            changed_q, changed_d;

    function automatic param_t sat_up(input param_t v);
        wide_t s;
        s = wide_t'(v) + STEP_X;
        if (s > MAX_X) s = MAX_X;
        return param_t'(s);
    endfunction

    function automatic param_t sat_dn(input param_t v);
        wide_t s;
        s = wide_t'(v) - STEP_X;
        if (s < MIN_X) s = MIN_X;
        return param_t'(s);
    endfunction

    // Next state, repeat timing and the write-back to the active mode register.
    always_comb begin
        logic   up_p, dn_p;
        param_t cur, nxt;

        state_d   = state_q;
        rpt_cnt_d = '0;
        changed_d = 1'b0;
        for (int i = 0; i < NUM_MODES; i++) begin
            params_d[i] = params_q[i];
        end
        up_p = ~key_db[0];
        dn_p = ~key_db[1];
        cur  = params_q[mode_q];
        nxt  = cur;

        if (mode_d != mode_q) begin
            // A mode switch cancels any key action in progress without stepping.
            if (state_q != S_IDLE) begin
                state_d = S_WAIT_RELEASE;
            end
        end else if (mode_q == '0) begin
            // Bypass: keys only matter for leaving WAIT_RELEASE.
            if (state_q == S_WAIT_RELEASE) begin
                if (!up_p && !dn_p) state_d = S_IDLE;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (up_p && dn_p) begin
                        state_d = S_BOTH;
                    end else if (up_p) begin
                        nxt     = sat_up(cur);
                        state_d = S_HOLD_UP;
                    end else if (dn_p) begin
                        nxt     = sat_dn(cur);
                        state_d = S_HOLD_DN;
                    end
                end
                S_HOLD_UP, S_REPEAT_UP: begin
                    if (dn_p) begin
                        state_d = S_BOTH;
                    end else if (!up_p) begin
                        state_d = S_IDLE;
                    end else if ((state_q == S_HOLD_UP  && rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) ||
                                 (state_q == S_REPEAT_UP && rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1))) begin
                        nxt     = sat_up(cur);
                        state_d = S_REPEAT_UP;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                S_HOLD_DN, S_REPEAT_DN: begin
                    if (up_p) begin
                        state_d = S_BOTH;
                    end else if (!dn_p) begin
                        state_d = S_IDLE;
                    end else if ((state_q == S_HOLD_DN  && rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) ||
                                 (state_q == S_REPEAT_DN && rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1))) begin
                        nxt     = sat_dn(cur);
                        state_d = S_REPEAT_DN;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                S_BOTH: begin
                    nxt     = DEF_P;
                    state_d = S_WAIT_RELEASE;
                end
                S_WAIT_RELEASE: begin
                    if (!up_p && !dn_p) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Only a real value change is written back and reported.
        if (nxt != cur) begin
            params_d[mode_q] = nxt;
            changed_d        = 1'b1;
        end
    end

    // FSM, repeat counter and change pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            rpt_cnt_q <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            changed_q <= changed_d;
        end
    end

    generate
        for (gi = 0; gi < NUM_MODES; gi++) begin : g_param
            // Per-mode parameter register, retained across mode switches.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    params_q[gi] <= DEF_P;
                end else begin
                    params_q[gi] <= params_d[gi];
                end
            end
        end
    endgenerate

    assign mode          = mode_q;
    assign param         = params_q[mode_q];
    assign param_changed = changed_q;

endmodule

// File: tb/tb_effect_param_controller.sv
// Directed bench for effect_param_controller with short debounce and repeat
// timings; expected values are worked out by hand from the key latency rules.
module tb_effect_param_controller;

    logic              CLK;
    logic              RST;
    logic              key_up;
    logic              key_down;
    logic [1:0]        SW;
    logic [1:0]        mode;
    logic signed [15:0] param;
    logic              param_changed;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int consec  = 0;
    int p0;
    logic prev_pc = 1'b0;

    effect_param_controller #(
        .NUM_MODES      (3),
        .SW_W           (2),
        .PARAM_W        (16),
        .PARAM_MIN      (1),
        .PARAM_MAX      (50),
        .PARAM_DEFAULT  (1),
        .STEP           (1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .key_up       (key_up),
        .key_down     (key_down),
        .SW           (SW),
        .mode         (mode),
        .param        (param),
        .param_changed(param_changed)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse monitor: counts change pulses and back-to-back pulses.
    always @(posedge CLK) begin
        if (param_changed) pulses++;
        if (param_changed && prev_pc) consec++;
        prev_pc = param_changed;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Short press of one key (released before auto-repeat can start).
    task automatic tap_up();
        key_up = 1'b0;
        wait_n(10);
        key_up = 1'b1;
        wait_n(12);
    endtask

    initial begin
        RST = 1'b1; key_up = 1'b1; key_down = 1'b1; SW = 2'd0;
        wait_n(3);
        check("rst_mode", int'(mode), 0);
        check("rst_param", int'(param), 1);
        check("rst_pulse", int'(param_changed), 0);
        RST = 1'b0;

        // Mode 2, down at minimum, then a single up step.
        SW = 2'd2;
        wait_n(4);
        check("m2_mode", int'(mode), 2);
        p0 = pulses;
        key_down = 1'b0;
        wait_n(12);
        check("dn_at_min_param", int'(param), 1);
        check("dn_at_min_pulse", pulses - p0, 0);
        key_down = 1'b1;
        wait_n(12);
        p0 = pulses;
        key_up = 1'b0;
        wait_n(7);
        check("up_edge6_param", int'(param), 1);
        wait_n(1);
        check("up_edge7_param", int'(param), 2);
        check("up_edge7_pulse", int'(param_changed), 1);
        key_up = 1'b1;
        wait_n(12);
        check("up_single_pulses", pulses - p0, 1);

        // Bounce: 2-cycle glitches never qualify, final stable low steps once.
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            key_up = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_n(2);
        end
        key_up = 1'b0;
        wait_n(7);
        check("bounce_edge6_param", int'(param), 2);
        wait_n(1);
        check("bounce_edge7_param", int'(param), 3);
        key_up = 1'b1;
        wait_n(12);
        check("bounce_pulses", pulses - p0, 1);

        // Mode 1 long hold: repeat timing and saturation.
        SW = 2'd1;
        wait_n(4);
        check("m1_mode", int'(mode), 1);
        check("m1_param", int'(param), 1);
        p0 = pulses;
        key_up = 1'b0;
        wait_n(8);
        check("hold_first", int'(param), 2);
        wait_n(19);
        check("hold_pre_delay", int'(param), 2);
        wait_n(1);
        check("hold_delay", int'(param), 3);
        wait_n(5);
        check("hold_rep1", int'(param), 4);
        wait_n(5);
        check("hold_rep2", int'(param), 5);
        wait_n(30);
        check("hold_60", int'(param), 11);
        wait_n(300);
        check("hold_sat", int'(param), 50);
        key_up = 1'b1;
        wait_n(12);
        check("hold_sat_after", int'(param), 50);
        check("hold_pulses", pulses - p0, 49);

        // Both keys: back to default with one pulse, nothing until both released.
        p0 = pulses;
        key_up = 1'b0; key_down = 1'b0;
        wait_n(8);
        check("both_edge7", int'(param), 50);
        wait_n(1);
        check("both_edge8", int'(param), 1);
        wait_n(20);
        key_up = 1'b1;
        wait_n(12);
        check("both_one_held", int'(param), 1);
        key_down = 1'b1;
        wait_n(12);
        check("both_param", int'(param), 1);
        check("both_pulses", pulses - p0, 1);

        // Set mode 1 to 10 by a timed hold (steps at 7,27,32..62).
        key_up = 1'b0;
        wait_n(58);
        key_up = 1'b1;
        wait_n(15);
        check("m1_set10", int'(param), 10);

        // Mode 2 to 5, check retention both ways.
        SW = 2'd2;
        wait_n(4);
        check("m2_retained", int'(param), 3);
        tap_up();
        tap_up();
        check("m2_set5", int'(param), 5);
        SW = 2'd1;
        wait_n(4);
        check("m1_retained", int'(param), 10);
        SW = 2'd2;
        wait_n(4);
        check("m2_retained5", int'(param), 5);

        // Out-of-range switch code is bypass; keys ignored.
        SW = 2'd3;
        wait_n(4);
        check("sw3_mode", int'(mode), 0);
        check("sw3_param", int'(param), 1);
        p0 = pulses;
        tap_up();
        check("sw3_pulses", pulses - p0, 0);
        SW = 2'd1;
        wait_n(4);
        check("sw3_m1_untouched", int'(param), 10);

        // Mode switch during REPEAT_DN: no step in either mode.
        key_down = 1'b0;
        wait_n(35);
        check("rdn_before_switch", int'(param), 7);
        p0 = pulses;
        SW = 2'd2;
        wait_n(30);
        check("rdn_switch_mode", int'(mode), 2);
        check("rdn_switch_m2", int'(param), 5);
        check("rdn_switch_pulses", pulses - p0, 0);
        SW = 2'd1;
        wait_n(5);
        check("rdn_back_m1", int'(param), 7);
        key_down = 1'b1;
        wait_n(12);
        check("rdn_released", int'(param), 7);
        key_down = 1'b0;
        wait_n(8);
        check("rdn_fresh_press", int'(param), 6);
        key_down = 1'b1;
        wait_n(12);

        // Reset mid-repeat: defaults, then exactly one step from the held key.
        key_up = 1'b0;
        wait_n(30);
        check("rst_mid_repeat_pre", int'(param), 8);
        RST = 1'b1;
        wait_n(2);
        check("rst_mid_mode", int'(mode), 0);
        check("rst_mid_param", int'(param), 1);
        check("rst_mid_pulse", int'(param_changed), 0);
        RST = 1'b0;
        p0 = pulses;
        wait_n(7);
        check("rst_rehold_edge6", int'(param), 1);
        wait_n(1);
        check("rst_rehold_edge7", int'(param), 2);
        key_up = 1'b1;
        wait_n(12);
        check("rst_rehold_pulses", pulses - p0, 1);
        SW = 2'd2;
        wait_n(4);
        check("rst_m2_default", int'(param), 1);

        check("no_consec_pulses", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
